// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU word type, PC increment and fetch-stage state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : Instruction fetch: PC, imem handshake, IF/ID write/flush, redirects.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              halt,
  output logic [WORD_W-1:0] ifinstr,
  output logic [WORD_W-1:0] ifJALjump_addr,
  output logic              ifW,
  output logic              ifRST,
  output logic [WORD_W-1:0] pc_out
);

  localparam word_t C_PC_RESET_ALIGNED = {PC_RESET[WORD_W-1:2], 2'b00};

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  word_t        r_pc;
  word_t        w_pc_next;
  word_t        r_pend_addr;
  word_t        w_pend_next;
  word_t        w_pc_inc;
  word_t        w_redirect_aligned;

  assign w_pc_inc           = r_pc + PC_INC;
  assign w_redirect_aligned = {redirect_addr[WORD_W-1:2], 2'b00};
  assign pc_out             = r_pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= FETCH;
      r_pc        <= C_PC_RESET_ALIGNED;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_pend_addr <= w_pend_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pend_next    = r_pend_addr;
    iREN           = 1'b1;
    iaddr          = r_pc;
    ifW            = 1'b1;
    ifRST          = 1'b1;
    ifinstr        = '0;
    ifJALjump_addr = '0;

    case (r_state)
      FETCH: begin
        if (halt) begin
          w_state_next = HALTED;
        end else if (redirect) begin
          // Without a hit the request to pc is still outstanding, so keep
          // iaddr stable and retire it in SQUASH before moving to the target.
          if (ihit) begin
            w_pc_next = w_redirect_aligned;
          end else begin
            w_pend_next  = w_redirect_aligned;
            w_state_next = SQUASH;
          end
        end else if (stall) begin
          ifW   = 1'b0;
          ifRST = 1'b0;
        end else if (ihit) begin
          ifRST          = 1'b0;
          ifinstr        = iload;
          ifJALjump_addr = w_pc_inc;
          w_pc_next      = w_pc_inc;
        end
      end

      SQUASH: begin
        if (halt) begin
          w_state_next = HALTED;
        end else begin
          if (redirect) begin
            w_pend_next = w_redirect_aligned;
          end
          if (ihit) begin
            w_pc_next    = redirect ? w_redirect_aligned : r_pend_addr;
            w_state_next = FETCH;
          end
        end
      end

      HALTED: begin
        iREN = 1'b0;
      end

      default: begin
        w_state_next = FETCH;
      end
    endcase

    // Hold a clean bubble on IF/ID while reset is asserted, regardless of inputs.
    if (!nRST) begin
      iREN           = 1'b1;
      ifW            = 1'b1;
      ifRST          = 1'b1;
      ifinstr        = '0;
      ifJALjump_addr = '0;
    end
  end

endmodule

`default_nettype wire
